// File: rtl/scan_pkg.sv
// Shared types and sizes for the channel scan sequencer.
package scan_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DWELL = 2'd1,
        HOLD  = 2'd2
    } state_t;

    localparam int CH_COUNT = 4;
    localparam int SEL_W    = 2;
    localparam int CNT_W    = 26;

endpackage

// File: rtl/scan_next_ch.sv
// Combinational search for the next enabled channel after cur, wrapping modulo 4.
// wrap flags a move whose new index is not above the old one (including self re-select).
module scan_next_ch
    import scan_pkg::*;
(
    input  logic [SEL_W-1:0]    cur,
    input  logic [CH_COUNT-1:0] mask,
    output logic [SEL_W-1:0]    nxt,
    output logic                wrap
);

    logic             found;
    logic [SEL_W-1:0] idx;

    // Offsets 1..4: offset 4 lands back on cur, so a lone enabled channel re-selects itself.
    always_comb begin
        nxt   = cur;
        found = 1'b0;
        idx   = cur;
        for (int k = 1; k <= CH_COUNT; k++) begin
            idx = cur + SEL_W'(k);
            if (!found && mask[idx]) begin
                nxt   = idx;
                found = 1'b1;
            end
        end
        wrap = (nxt <= cur);
    end

endmodule

// File: rtl/channel_scan_sequencer.sv
// Round-robin dwell sequencer over the enabled channels of a 4:1 mux select.
// Optional manual step advance is compiled in when SCAN_STEP_EN is defined.
module channel_scan_sequencer
    import scan_pkg::*;
#(
    parameter int DWELL_CYCLES = 50000000
) (
    input  logic                CLOCK_50,
    input  logic                RESET_N,
    input  logic                run,
    input  logic [3:0]          ch_en,
    input  logic                step,
    output logic [1:0]          sel,
    output logic                sel_valid,
    output logic                wrap,
    output logic [CNT_W-1:0]    dwell_cnt
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DWELL_CYCLES - 1);

    state_t           state_q, state_d;
    logic [1:0]       sel_d;
    logic             sel_valid_d;
    logic             wrap_d;
    logic [CNT_W-1:0] cnt_d;
    logic             advance;
    logic [1:0]       search_cur;
    logic [1:0]       next_sel;
    logic             next_wrap;
    logic             step_req;

`ifdef SCAN_STEP_EN
    assign step_req = step;
`else
    logic unused_step;
    assign unused_step = step;
    assign step_req    = 1'b0;
`endif

    // From IDLE, searching after the top index yields the lowest enabled channel.
    assign search_cur = (state_q == IDLE) ? 2'(CH_COUNT - 1) : sel;

    scan_next_ch u_next (
        .cur  (search_cur),
        .mask (ch_en),
        .nxt  (next_sel),
        .wrap (next_wrap)
    );

    always_comb begin
        state_d     = state_q;
        sel_d       = sel;
        sel_valid_d = sel_valid;
        wrap_d      = 1'b0;
        cnt_d       = dwell_cnt;
        advance     = 1'b0;

        if (ch_en == 4'b0000) begin
            state_d     = IDLE;
            sel_valid_d = 1'b0;
            cnt_d       = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (run) begin
                        state_d     = DWELL;
                        sel_d       = next_sel;
                        sel_valid_d = 1'b1;
                        cnt_d       = '0;
                    end
                end
                DWELL: begin
                    if (!ch_en[sel])               advance = 1'b1;
                    else if (!run)                 state_d = HOLD;
                    else if (step_req)             advance = 1'b1;
                    else if (dwell_cnt == LAST_CNT) advance = 1'b1;
                    else                           cnt_d   = dwell_cnt + 1'b1;
                end
                HOLD: begin
                    if (!ch_en[sel]) begin
                        advance = 1'b1;
                    end else begin
                        if (run)      state_d = DWELL;
                        if (step_req) advance = 1'b1;
                    end
                end
                default: begin
                    state_d     = IDLE;
                    sel_valid_d = 1'b0;
                    cnt_d       = '0;
                end
            endcase

            if (advance) begin
                sel_d  = next_sel;
                wrap_d = next_wrap;
                cnt_d  = '0;
            end
        end
    end

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q   <= IDLE;
            sel       <= '0;
            sel_valid <= 1'b0;
            wrap      <= 1'b0;
            dwell_cnt <= '0;
        end else begin
            state_q   <= state_d;
            sel       <= sel_d;
            sel_valid <= sel_valid_d;
            wrap      <= wrap_d;
            dwell_cnt <= cnt_d;
        end
    end

endmodule

// File: tb/tb_channel_scan_sequencer.sv
// Self-checking bench for channel_scan_sequencer with DWELL_CYCLES=4 (SCAN_STEP_EN aware).
module tb_channel_scan_sequencer;

    localparam int DW = 4;
`ifdef SCAN_STEP_EN
    localparam bit STEP_EN = 1'b1;
`else
    localparam bit STEP_EN = 1'b0;
`endif

    logic        clk;
    logic        rst_n;
    logic        run;
    logic [3:0]  ch_en;
    logic        step;
    logic [1:0]  sel;
    logic        sel_valid;
    logic        wrap;
    logic [25:0] dwell_cnt;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    // reference model state
    bit         m_active;
    bit         m_hold;
    logic [1:0] m_sel;
    bit         m_valid;
    bit         m_wrap;
    int         m_cnt;

    int         obs_wraps;
    logic [3:0] seen;
    logic [1:0] saved_sel;

    channel_scan_sequencer #(.DWELL_CYCLES(DW)) dut (
        .CLOCK_50  (clk),
        .RESET_N   (rst_n),
        .run       (run),
        .ch_en     (ch_en),
        .step      (step),
        .sel       (sel),
        .sel_valid (sel_valid),
        .wrap      (wrap),
        .dwell_cnt (dwell_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [1:0] next_en(input logic [1:0] cur, input logic [3:0] m);
        for (int k = 1; k <= 4; k++)
            if (m[(int'(cur) + k) % 4]) return 2'((int'(cur) + k) % 4);
        return cur;
    endfunction

    function automatic logic [1:0] lowest_en(input logic [3:0] m);
        for (int i = 0; i < 4; i++)
            if (m[i]) return 2'(i);
        return 2'd0;
    endfunction

    task automatic model_reset();
        m_active = 0; m_hold = 0; m_sel = 2'd0; m_valid = 0; m_wrap = 0; m_cnt = 0;
    endtask

    task automatic model_step();
        logic [1:0] n;
        bit adv;
        adv    = 0;
        m_wrap = 0;
        if (!rst_n) begin
            model_reset();
        end else if (ch_en == 4'b0000) begin
            m_active = 0; m_hold = 0; m_valid = 0; m_cnt = 0;
        end else if (!m_active) begin
            if (run) begin
                m_active = 1; m_hold = 0; m_sel = lowest_en(ch_en); m_valid = 1; m_cnt = 0;
            end
        end else begin
            if (!ch_en[m_sel]) adv = 1;
            else if (!m_hold) begin
                if (!run)                 m_hold = 1;
                else if (STEP_EN && step) adv = 1;
                else if (m_cnt == DW - 1) adv = 1;
                else                      m_cnt++;
            end else begin
                if (run)             m_hold = 0;
                if (STEP_EN && step) adv = 1;
            end
            if (adv) begin
                n      = next_en(m_sel, ch_en);
                m_wrap = (n <= m_sel);
                m_sel  = n;
                m_cnt  = 0;
            end
        end
    endtask

    task automatic compare_all();
        check("sel", 32'(sel), 32'(m_sel));
        check("sel_valid", 32'(sel_valid), 32'(m_valid));
        check("wrap", 32'(wrap), 32'(m_wrap));
        check("dwell_cnt", 32'(dwell_cnt), m_cnt);
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        compare_all();
        if (wrap === 1'b1) obs_wraps++;
        seen[sel] = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0; run = 1'b0; ch_en = 4'b0000; step = 1'b0;
        model_reset();
        #12;
        check("reset_sel", 32'(sel), 0);
        check("reset_valid", 32'(sel_valid), 0);
        check("reset_wrap", 32'(wrap), 0);
        check("reset_cnt", 32'(dwell_cnt), 0);

        // full scan from reset
        @(negedge clk);
        rst_n = 1'b1; ch_en = 4'b1111; run = 1'b1;
        obs_wraps = 0;
        tick();
        check("entry_sel", 32'(sel), 0);
        check("entry_wrap", 32'(wrap), 0);
        for (int i = 0; i < 19; i++) tick();
        check("scan_wraps", obs_wraps, 1);
        check("scan_back_to0", 32'(sel), 0);

        // alternating 1,3
        ch_en = 4'b1010;
        tick();
        check("alt_first", 32'(sel), 1);
        obs_wraps = 0; seen = 4'b0000;
        for (int i = 0; i < 23; i++) tick();
        check("alt_seen", 32'(seen), 32'(4'b1010));
        check("alt_wraps", obs_wraps, 2);

        // run dropped at dwell_cnt=2
        for (int i = 0; i < 20 && dwell_cnt != 26'd2; i++) tick();
        check("reach_cnt2", 32'(dwell_cnt), 2);
        saved_sel = sel;
        run = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("hold_cnt", 32'(dwell_cnt), 2);
            check("hold_sel", 32'(sel), 32'(saved_sel));
            check("hold_valid", 32'(sel_valid), 1);
        end
        run = 1'b1;
        tick();
        tick();
        check("resume_cnt3", 32'(dwell_cnt), 3);
        tick();
        check("resume_adv_sel", 32'(sel), 32'(next_en(saved_sel, 4'b1010)));
        check("resume_adv_cnt", 32'(dwell_cnt), 0);

        // current channel disabled mid-dwell, then all disabled
        ch_en = 4'b1111;
        for (int i = 0; i < 40 && !(sel == 2'd2 && dwell_cnt == 26'd1); i++) tick();
        check("reach_sel2", 32'(sel), 2);
        ch_en = 4'b1011;
        tick();
        check("dis_sel", 32'(sel), 3);
        check("dis_cnt", 32'(dwell_cnt), 0);
        ch_en = 4'b0000;
        tick();
        check("off_valid", 32'(sel_valid), 0);
        check("off_sel", 32'(sel), 3);
        check("off_cnt", 32'(dwell_cnt), 0);

        // manual step while held
        ch_en = 4'b1111; run = 1'b1;
        tick();
        check("step_entry", 32'(sel), 0);
        tick();
        run = 1'b0;
        tick();
        step = 1'b1;
        tick();
        step = 1'b0;
        check("step_sel", 32'(sel), STEP_EN ? 1 : 0);
        check("step_cnt", 32'(dwell_cnt), STEP_EN ? 0 : 1);
        tick();
        check("step_still_hold", 32'(sel), STEP_EN ? 1 : 0);

        // randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 19) == 0) ch_en = 4'($urandom_range(0, 15));
            run  = ($urandom_range(0, 9) != 0);
            step = ($urandom_range(0, 7) == 0);
            tick();
        end

        // asynchronous reset mid-scan
        ch_en = 4'b1111; run = 1'b1; step = 1'b0;
        for (int i = 0; i < 40 && !(sel == 2'd2 && sel_valid == 1'b1); i++) tick();
        check("reach_sel2_rst", 32'(sel), 2);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        compare_all();
        tick();
        #3;
        rst_n = 1'b1; ch_en = 4'b0100; run = 1'b1;
        tick();
        check("post_rst_sel", 32'(sel), 2);
        check("post_rst_valid", 32'(sel_valid), 1);
        for (int i = 0; i < 6; i++) tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
